// File: rtl/io_pkg.sv
// Shared constants for the MMIO UART port: register window, register offsets,
// TXCTRL bit positions and the transmitter state encoding.
package io_pkg;

    localparam logic [31:0] IO_BASE = 32'hFFFF_0000;

    localparam logic [3:0] OFF_PORTIN  = 4'h0;
    localparam logic [3:0] OFF_PORTOUT = 4'h4;
    localparam logic [3:0] OFF_TXCTRL  = 4'h8;
    localparam logic [3:0] OFF_TXDATA  = 4'hC;

    localparam int TXCTRL_READY = 0;
    localparam int TXCTRL_BUSY  = 1;
    localparam int TXCTRL_OVF   = 2;

    // Gray-ordered so each step around the frame flips a single state bit.
    typedef enum logic [1:0] {
        TX_IDLE  = 2'b00,
        TX_START = 2'b01,
        TX_DATA  = 2'b11,
        TX_STOP  = 2'b10
    } txState_t;

    function automatic logic [31:0] txCtrlWord(input logic ready, input logic busy,
                                               input logic ovf);
        logic [31:0] word;
        word               = '0;
        word[TXCTRL_READY] = ready;
        word[TXCTRL_BUSY]  = busy;
        word[TXCTRL_OVF]   = ovf;
        return word;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO. A push into a full FIFO is accepted when a pop
// happens on the same edge; otherwise it is discarded.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [CW-1:0]    count;
    logic             doPush;
    logic             doPop;

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign doPop  = pop & ~empty;
    assign doPush = push & (~full | doPop);
    assign dout   = mem[rdPtr];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop)  rdPtr <= rdPtr + AW'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; empty/full come from the counter, so stale
    // entries are never observed and the array can map onto plain RAM cells.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= din;
    end

endmodule

// File: rtl/mmio_uart_port.sv
// MMIO peripheral on the core's data bus: PORTOUT register, synchronised PortIn
// sample, and a FIFO-buffered 8N1 UART transmitter.
module mmio_uart_port #(
    parameter logic [31:0] IO_BASE    = io_pkg::IO_BASE,
    parameter int          CLK_DIV    = 434,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [7:0]  PortIn,
    output logic [31:0] ReadData,
    output logic        io_hit,
    output logic        tx,
    output logic [31:0] PortOut
);

    import io_pkg::*;

    logic [3:0] offset;
    logic       wrEn;
    logic       txPush;
    logic [7:0] pinMeta;
    logic [7:0] pinSync;
    logic       ovf;

    logic       fifoPop;
    logic       fifoFull;
    logic       fifoEmpty;
    logic [7:0] fifoDout;

    txState_t   state, stateNext;
    logic [7:0]  shiftReg, shiftNext;
    logic [15:0] baudCnt, cntNext;
    logic [2:0]  bitIdx, bitNext;
    logic        txReg, txNext;
    logic        bitDone;

    assign offset = Address[3:0];
    assign io_hit = (Address[31:4] == IO_BASE[31:4]);
    assign wrEn   = io_hit & MemWrite;
    assign txPush = wrEn & (offset == OFF_TXDATA);
    assign tx     = txReg;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) txFifo (
        .clk   (clk),
        .reset (reset),
        .push  (txPush),
        .pop   (fifoPop),
        .din   (WriteData[7:0]),
        .dout  (fifoDout),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pinMeta <= '0;
            pinSync <= '0;
            PortOut <= '0;
            ovf     <= 1'b0;
        end else begin
            pinMeta <= PortIn;
            pinSync <= pinMeta;
            if (wrEn && offset == OFF_PORTOUT) PortOut <= WriteData;
            // A full-FIFO push is only lost when the transmitter is not popping.
            if (txPush && fifoFull && !fifoPop)
                ovf <= 1'b1;
            else if (wrEn && offset == OFF_TXCTRL && WriteData[TXCTRL_OVF])
                ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= TX_IDLE;
            shiftReg <= '0;
            baudCnt  <= '0;
            bitIdx   <= '0;
            txReg    <= 1'b1;
        end else begin
            state    <= stateNext;
            shiftReg <= shiftNext;
            baudCnt  <= cntNext;
            bitIdx   <= bitNext;
            txReg    <= txNext;
        end
    end

    assign bitDone = (baudCnt == 16'(CLK_DIV - 1));

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        stateNext = state;
        shiftNext = shiftReg;
        cntNext   = baudCnt;
        bitNext   = bitIdx;
        fifoPop   = 1'b0;
        txNext    = 1'b1;

        case (state)
            TX_IDLE: begin
                if (!fifoEmpty) begin
                    fifoPop   = 1'b1;
                    shiftNext = fifoDout;
                    cntNext   = '0;
                    bitNext   = '0;
                    stateNext = TX_START;
                end
            end
            TX_START: begin
                if (bitDone) begin
                    cntNext   = '0;
                    stateNext = TX_DATA;
                end else begin
                    cntNext = baudCnt + 16'd1;
                end
            end
            TX_DATA: begin
                if (bitDone) begin
                    cntNext   = '0;
                    shiftNext = shiftReg >> 1;
                    bitNext   = bitIdx + 3'd1;
                    if (bitIdx == 3'd7) stateNext = TX_STOP;
                end else begin
                    cntNext = baudCnt + 16'd1;
                end
            end
            TX_STOP: begin
                if (bitDone) begin
                    cntNext   = '0;
                    stateNext = TX_IDLE;
                end else begin
                    cntNext = baudCnt + 16'd1;
                end
            end
            default: stateNext = TX_IDLE;
        endcase

        // The line level is registered from the next state so tx never glitches.
        case (stateNext)
            TX_START: txNext = 1'b0;
            TX_DATA:  txNext = shiftNext[0];
            default:  txNext = 1'b1;
        endcase
    end

    always_comb begin
        ReadData = '0;
        if (io_hit && MemRead) begin
            case (offset)
                OFF_PORTIN:  ReadData = {24'b0, pinSync};
                OFF_PORTOUT: ReadData = PortOut;
                OFF_TXCTRL:  ReadData = txCtrlWord(!fifoFull,
                                                   (state != TX_IDLE) || !fifoEmpty,
                                                   ovf);
                default:     ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_port.sv
// Self-checking bench for mmio_uart_port: directed bus sequence with random data,
// frame-level transmitter model and a serial-line receiver.
module tb_mmio_uart_port;

    localparam int          CD    = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] WriteData = '0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [7:0]  PortIn = '0;
    logic [31:0] ReadData;
    logic        io_hit;
    logic        tx;
    logic [31:0] PortOut;

    mmio_uart_port #(.IO_BASE(BASE), .CLK_DIV(CD), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .Address   (Address),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .PortIn    (PortIn),
        .ReadData  (ReadData),
        .io_hit    (io_hit),
        .tx        (tx),
        .PortOut   (PortOut)
    );

    always #5 clk = ~clk;

    int passCnt  = 0;
    int totalCnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference model: bytes waiting for the transmitter, bytes already on the
    // wire, and the edge at which the transmitter can take the next byte.
    logic [7:0]  pend[$];
    logic [7:0]  expQ[$];
    int          edgeNo   = 0;
    int          txFreeAt = 0;
    bit          ovfM     = 1'b0;
    logic [31:0] portOutM = '0;

    function automatic bit busyM();
        return (pend.size() > 0) || (edgeNo < txFreeAt - 1);
    endfunction

    function automatic logic [31:0] expCtrl();
        return {29'b0, ovfM, busyM(), pend.size() < DEPTH};
    endfunction

    function automatic logic frameBit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return d[k-1];
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend.delete();
            expQ.delete();
            ovfM     = 1'b0;
            portOutM = '0;
            txFreeAt = 0;
        end else begin
            edgeNo++;
            if (pend.size() > 0 && edgeNo >= txFreeAt) begin
                expQ.push_back(pend.pop_front());
                txFreeAt = edgeNo + 10 * CD + 1;
            end
            if (MemWrite && Address[31:4] == BASE[31:4]) begin
                case (Address[3:0])
                    4'h4: portOutM = WriteData;
                    4'h8: if (WriteData[2]) ovfM = 1'b0;
                    4'hC: if (pend.size() < DEPTH) pend.push_back(WriteData[7:0]);
                          else ovfM = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Serial receiver: samples each bit in the middle of its CD-cycle slot.
    int         rxCount  = 0;
    bit         rxActive = 1'b0;
    int         rxCnt    = 0;
    int         rxK      = 0;
    logic [7:0] rxByte   = '0;

    always @(negedge clk) begin
        if (!reset) begin
            rxActive = 1'b0;
        end else if (!rxActive) begin
            if (tx === 1'b0) begin
                rxActive = 1'b1;
                rxCnt    = 0;
            end
        end else begin
            rxCnt++;
            if (rxCnt % CD == CD / 2) begin
                rxK = rxCnt / CD;
                if (rxK == 0) begin
                    check("rxStart", tx, 0);
                end else if (rxK <= 8) begin
                    rxByte[rxK-1] = tx;
                end else begin
                    check("rxStop", tx, 1);
                    check("rxPending", expQ.size() > 0, 1);
                    if (expQ.size() > 0) check("rxByte", rxByte, expQ.pop_front());
                    rxCount++;
                    rxActive = 1'b0;
                end
            end
        end
    end

    task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
        Address   = addr;
        WriteData = data;
        MemWrite  = 1'b1;
        MemRead   = 1'b0;
        @(negedge clk);
        MemWrite  = 1'b0;
    endtask

    task automatic readCheck(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        Address = addr;
        MemRead = 1'b1;
        #1;
        check(tag, ReadData, exp);
        MemRead = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  d;
        logic [7:0]  oldPin;
        logic [31:0] v;
        bit          found;
        int          rxBase;

        // Reset state
        PortIn = 8'hFF;
        repeat (2) @(negedge clk);
        check("rstTx", tx, 1);
        check("rstPortOut", PortOut, 32'h0);
        readCheck("rstCtrl", BASE | 32'h8, 32'h1);
        readCheck("rstPortIn", BASE, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // PORTOUT write, read-back, ignored writes
        v = $urandom | 32'h1;
        busWrite(BASE | 32'h4, 32'hDEADBEEF);
        check("portOut", PortOut, portOutM);
        check("portOutConst", PortOut, 32'hDEADBEEF);
        readCheck("portOutRead", BASE | 32'h4, portOutM);
        @(negedge clk);
        busWrite(BASE | 32'h6, v);
        check("unalignedWrite", PortOut, portOutM);
        busWrite(32'h1001_0004, v);
        check("missWrite", PortOut, portOutM);
        readCheck("unalignedRead", BASE | 32'h6, 32'h0);
        readCheck("txdataRead", BASE | 32'hC, 32'h0);
        Address = 32'h1001_0004; MemRead = 1'b1; #1;
        check("missHit", io_hit, 0);
        check("missData", ReadData, 32'h0);
        Address = BASE | 32'h4; MemRead = 1'b0; #1;
        check("hitNoRead", io_hit, 1);
        check("noReadData", ReadData, 32'h0);

        // PortIn synchroniser latency
        for (int i = 0; i < 5; i++) begin
            d      = (i == 0) ? 8'h3C : 8'($urandom);
            oldPin = d ^ 8'(1 + $urandom_range(0, 254));
            @(negedge clk);
            PortIn = oldPin;
            repeat (3) @(negedge clk);
            #2 PortIn = d;
            @(posedge clk); #1;
            readCheck("pinEdge1", BASE, {24'b0, oldPin});
            @(posedge clk); #1;
            readCheck("pinEdge2", BASE, {24'b0, d});
        end
        @(negedge clk);

        // Single frames, checked cycle by cycle
        for (int f = 0; f < 2; f++) begin
            d = (f == 0) ? 8'hA5 : 8'($urandom);
            busWrite(BASE | 32'hC, {24'($urandom), d});
            check("preStartTx", tx, 1);
            readCheck("preStartCtrl", BASE | 32'h8, expCtrl());
            for (int c = 0; c < 10 * CD; c++) begin
                @(negedge clk);
                check("frameBit", tx, frameBit(d, c / CD));
                readCheck("frameCtrl", BASE | 32'h8, expCtrl());
                @(negedge clk);
                c++;
                check("frameBit", tx, frameBit(d, c / CD));
            end
            @(negedge clk);
            check("postStopTx", tx, 1);
            readCheck("postStopCtrl", BASE | 32'h8, 32'h1);
            @(negedge clk);
        end

        // Burst of six stores: one popped, four queued, one dropped
        rxBase = rxCount;
        for (int i = 0; i < 6; i++) begin
            Address = BASE | 32'hC; WriteData = $urandom; MemWrite = 1'b1;
            @(negedge clk);
        end
        MemWrite = 1'b0;
        readCheck("burstCtrl", BASE | 32'h8, expCtrl());
        check("burstCtrlConst", ReadData, 32'h6);
        busWrite(BASE | 32'h8, 32'h4);
        readCheck("ovfClear", BASE | 32'h8, expCtrl());
        check("ovfClearConst", ReadData, 32'h2);

        // Push into a full FIFO on the edge the transmitter pops
        @(negedge clk);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (edgeNo + 1 == txFreeAt) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("popEdgeFound", found, 1);
        busWrite(BASE | 32'hC, $urandom);
        readCheck("pushOnPop", BASE | 32'h8, expCtrl());
        check("pushOnPopConst", ReadData, 32'h2);

        // Drain everything
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busyM() && expQ.size() == 0 && !rxActive) begin
                found = 1'b1;
                break;
            end
        end
        check("drained", found, 1);
        check("frameCount", rxCount - rxBase, 6);
        readCheck("drainCtrl", BASE | 32'h8, 32'h1);

        // Asynchronous reset in the middle of a frame
        @(negedge clk);
        busWrite(BASE | 32'h4, $urandom | 32'h1);
        busWrite(BASE | 32'hC, $urandom);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tx === 1'b0) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("midStart", found, 1);
        PortIn = 8'hFF;
        rxBase = rxCount;
        Address = BASE | 32'h8; MemRead = 1'b1;
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check("midRstTx", tx, 1);
        check("midRstPortOut", PortOut, 32'h0);
        readCheck("midRstCtrl", BASE | 32'h8, 32'h1);
        readCheck("midRstPortIn", BASE, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (60) @(negedge clk);
        check("afterRstTx", tx, 1);
        check("afterRstFrames", rxCount, rxBase);
        readCheck("afterRstCtrl", BASE | 32'h8, expCtrl());

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
